wb_grf: RTL and testbench
=========================

WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 The block SHALL have these ports, one per line, in this order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- nInstr_W  in  32  W-stage instruction word
- pc_W  in  32  W-stage PC, unused internally, kept for trace
- pcPlus8_W  in  32  link value
- aluRes_W  in  32  ALU result
- extImm_W  in  32  extended immediate, already shifted for lui
- dmData_W  in  32  load data
- rsAddr_D  in  5  D-stage read address A
- rtAddr_D  in  5  D-stage read address B
- rsData_D  out  32  read data A
- rtData_D  out  32  read data B
- wbEn_W  out  1  W-stage write commit this cycle
- wbAddr_W  out  5  destination register
- wbData_W  out  32  write data, for forwarding

Function
REQ-002 Destination decode SHALL be combinational from nInstr_W:
- R-type (op 000000) with funct 100000 (add) or 100010 (sub): rd, aluRes_W.
- ori (op 001101): rt, aluRes_W.
- lw (op 100011): rt, dmData_W.
- lui (op 001111): rt, extImm_W.
- jal (op 000011): register 31, pcPlus8_W.
- Any other encoding, including 0x00000000 (nop), sw, beq and jr: no write, wbAddr_W=0, wbData_W=0.
REQ-003 wbEn_W SHALL be 1 only when the decode selects a write and wbAddr_W is nonzero.
REQ-004 The block SHALL hold 32 x 32-bit registers.
REQ-005 On a rising clk edge with wbEn_W=1 and reset=0, the register at wbAddr_W SHALL take wbData_W, with one-cycle write latency.
REQ-006 Register 0 SHALL never be written and SHALL always read 0.
REQ-007 Reads SHALL be combinational with zero latency.
REQ-008 If wbEn_W=1 and a read address equals wbAddr_W, the read SHALL return wbData_W in the same cycle (internal W-to-D bypass).
REQ-009 Both read ports SHALL be independent; equal rsAddr_D and rtAddr_D SHALL return identical data.
REQ-010 The W-stage pipeline register supplying the inputs holds its contents when stalled; the block SHALL therefore rewrite the same value each cycle, which is idempotent and requires no extra gating.

Reset
REQ-011 While reset=1 at a rising clk edge, all 32 registers SHALL clear to 0, and any concurrent write SHALL be discarded.
REQ-012 The bypass SHALL stay active during reset, so reads reflect wbData_W when addresses match; register contents are 0 after the edge.
REQ-013 A reset asserted mid-sequence SHALL clear all state in exactly one edge; the first write after reset deasserts SHALL commit normally.

Structure
REQ-014 Opcode and funct constants (OP_RTYPE, OP_ORI, OP_LW, OP_LUI, OP_JAL, FN_ADD, FN_SUB) and the link register index 31 SHALL live in the shared CPU definitions package.
REQ-015 The destination/data decode SHALL be one combinational sub-module, wb_decode; the register array and bypass SHALL stay in wb_grf.

Verification
REQ-016 Reset, then read all 32 addresses -> every read returns 0x00000000.
REQ-017 ori $5 (rt=5) with aluRes_W=0x0000ABCD, then rsAddr_D=5 -> rsData_D=0x0000ABCD in the same cycle via bypass and on the next cycle from the array.
REQ-018 lui $0 with extImm_W=0x12340000 -> wbEn_W=0, and reading $0 returns 0.
REQ-019 jal with pcPlus8_W=0x00003008 -> wbAddr_W=31, and $31 reads 0x00003008 after the edge.
REQ-020 lw $7 with dmData_W=0xDEADBEEF while rsAddr_D=rtAddr_D=7 -> both reads return 0xDEADBEEF in the write cycle.
REQ-021 Write $3=0x11111111, then assert reset in the same cycle as an add to $3 with value 0x22222222 -> $3 reads 0 after the edge.

Source files
------------

// File: rtl/wb_grf_pkg.sv
// Shared CPU definitions for the write-back stage and general register file:
// opcode/funct encodings, the link register index and the write-source select.
package wb_grf_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  localparam logic [4:0] REG_LINK = 5'd31;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_ALU  = 3'd1,
    SRC_DM   = 3'd2,
    SRC_IMM  = 3'd3,
    SRC_LINK = 3'd4
  } wb_src_e;

endpackage

// File: rtl/wb_decode.sv
// W-stage destination and write-data decode, purely combinational from the
// instruction word; non-writing encodings report address 0 and data 0.
module wb_decode
  import wb_grf_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] alu_res,
  input  logic [31:0] ext_imm,
  input  logic [31:0] dm_data,
  input  logic [31:0] pc_plus8,
  output logic        wr_sel,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  wb_src_e    src_s;
  logic       unused_s;

  assign op_s     = instr[31:26];
  assign funct_s  = instr[5:0];
  assign rt_s     = instr[20:16];
  assign rd_s     = instr[15:11];
  assign unused_s = ^{instr[25:21], instr[10:6]};

  // Select the data source and destination register from the opcode.
  always_comb begin
    src_s   = SRC_NONE;
    wr_addr = 5'd0;
    case (op_s)
      OP_RTYPE: begin
        if ((funct_s == FN_ADD) || (funct_s == FN_SUB)) begin
          src_s   = SRC_ALU;
          wr_addr = rd_s;
        end else begin
          src_s   = SRC_NONE;
          wr_addr = 5'd0;
        end
      end
      OP_ORI: begin
        src_s   = SRC_ALU;
        wr_addr = rt_s;
      end
      OP_LW: begin
        src_s   = SRC_DM;
        wr_addr = rt_s;
      end
      OP_LUI: begin
        src_s   = SRC_IMM;
        wr_addr = rt_s;
      end
      OP_JAL: begin
        src_s   = SRC_LINK;
        wr_addr = REG_LINK;
      end
      default: begin
        src_s   = SRC_NONE;
        wr_addr = 5'd0;
      end
    endcase
  end

  // Route the selected source onto the write-data bus.
  always_comb begin
    wr_data = 32'd0;
    case (src_s)
      SRC_ALU:  wr_data = alu_res;
      SRC_DM:   wr_data = dm_data;
      SRC_IMM:  wr_data = ext_imm;
      SRC_LINK: wr_data = pc_plus8;
      default:  wr_data = 32'd0;
    endcase
  end

  assign wr_sel = (src_s != SRC_NONE);

endmodule

// File: rtl/wb_grf.sv
// General register file with W-stage write-back decode and a W-to-D bypass
// so a decode-stage read sees the value being committed in the same cycle.
module wb_grf
  import wb_grf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nInstr_W,
  input  logic [31:0] pc_W,
  input  logic [31:0] pcPlus8_W,
  input  logic [31:0] aluRes_W,
  input  logic [31:0] extImm_W,
  input  logic [31:0] dmData_W,
  input  logic [4:0]  rsAddr_D,
  input  logic [4:0]  rtAddr_D,
  output logic [31:0] rsData_D,
  output logic [31:0] rtData_D,
  output logic        wbEn_W,
  output logic [4:0]  wbAddr_W,
  output logic [31:0] wbData_W
);

  // Register 0 is hard-wired to zero, so no storage is kept for it.
  logic [31:0] regs_r [31:1];
  logic        wr_sel_s;
  logic        unused_s;

  assign unused_s = ^pc_W;

  wb_decode u_decode (
    .instr    (nInstr_W),
    .alu_res  (aluRes_W),
    .ext_imm  (extImm_W),
    .dm_data  (dmData_W),
    .pc_plus8 (pcPlus8_W),
    .wr_sel   (wr_sel_s),
    .wr_addr  (wbAddr_W),
    .wr_data  (wbData_W)
  );

  assign wbEn_W = wr_sel_s && (wbAddr_W != 5'd0);

  // Register array: reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wbEn_W) begin
      regs_r[wbAddr_W] <= wbData_W;
    end
  end

  // Read ports with bypass; the bypass is not gated by reset.
  always_comb begin
    if (wbEn_W && (rsAddr_D == wbAddr_W)) begin
      rsData_D = wbData_W;
    end else if (rsAddr_D == 5'd0) begin
      rsData_D = 32'd0;
    end else begin
      rsData_D = regs_r[rsAddr_D];
    end
    if (wbEn_W && (rtAddr_D == wbAddr_W)) begin
      rtData_D = wbData_W;
    end else if (rtAddr_D == 5'd0) begin
      rtData_D = 32'd0;
    end else begin
      rtData_D = regs_r[rtAddr_D];
    end
  end

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed vectors, a register-array model
// checked every cycle, and hand-computed literal expectations.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nInstr_W, pc_W, pcPlus8_W, aluRes_W, extImm_W, dmData_W;
  logic [4:0]  rsAddr_D, rtAddr_D;
  logic [31:0] rsData_D, rtData_D;
  logic        wbEn_W;
  logic [4:0]  wbAddr_W;
  logic [31:0] wbData_W;

  int checks = 0;
  int failures = 0;
  logic chk_on = 1'b0;
  logic [31:0] model_regs [32];

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_grf dut (
    .clk(clk), .reset(reset), .nInstr_W(nInstr_W), .pc_W(pc_W),
    .pcPlus8_W(pcPlus8_W), .aluRes_W(aluRes_W), .extImm_W(extImm_W),
    .dmData_W(dmData_W), .rsAddr_D(rsAddr_D), .rtAddr_D(rtAddr_D),
    .rsData_D(rsData_D), .rtData_D(rtData_D), .wbEn_W(wbEn_W),
    .wbAddr_W(wbAddr_W), .wbData_W(wbData_W)
  );

  always #5 clk = ~clk;

  function automatic wb_t model_wb(input logic [31:0] ins, input logic [31:0] alu,
                                   input logic [31:0] imm, input logic [31:0] dm,
                                   input logic [31:0] pc8);
    wb_t r;
    logic [5:0] op;
    logic [5:0] fn;
    logic hit;
    op = ins[31:26];
    fn = ins[5:0];
    r = '0;
    hit = 1'b1;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin r.addr = ins[15:11]; r.data = alu; end
    else if (op == 6'h0D) begin r.addr = ins[20:16]; r.data = alu; end
    else if (op == 6'h23) begin r.addr = ins[20:16]; r.data = dm; end
    else if (op == 6'h0F) begin r.addr = ins[20:16]; r.data = imm; end
    else if (op == 6'h03) begin r.addr = 5'd31; r.data = pc8; end
    else hit = 1'b0;
    r.en = hit && (r.addr != 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] model_read(input wb_t w, input logic [4:0] a);
    if (w.en && a == w.addr) return w.data;
    return (a == 5'd0) ? 32'd0 : model_regs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
  end

  // Model state update on the active edge (inputs are stable here).
  always @(posedge clk) begin
    wb_t w;
    w = model_wb(nInstr_W, aluRes_W, extImm_W, dmData_W, pcPlus8_W);
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
    end else if (w.en) begin
      model_regs[w.addr] <= w.data;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    wb_t w;
    if (chk_on) begin
      w = model_wb(nInstr_W, aluRes_W, extImm_W, dmData_W, pcPlus8_W);
      check("cyc_wbEn", {31'd0, wbEn_W}, {31'd0, w.en});
      check("cyc_wbAddr", {27'd0, wbAddr_W}, {27'd0, w.addr});
      check("cyc_wbData", wbData_W, w.data);
      check("cyc_rsData", rsData_D, model_read(w, rsAddr_D));
      check("cyc_rtData", rtData_D, model_read(w, rtAddr_D));
    end
  end

  task automatic apply(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] imm,
                       input logic [31:0] dm, input logic [31:0] pc8,
                       input logic [4:0] rs, input logic [4:0] rt, input logic rst);
    nInstr_W = ins; aluRes_W = alu; extImm_W = imm; dmData_W = dm; pcPlus8_W = pc8;
    pc_W = pc8 - 32'd8; rsAddr_D = rs; rtAddr_D = rt; reset = rst;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
    next_cycle();
    chk_on = 1'b1;

    // All 32 addresses read zero after reset.
    for (int i = 0; i < 32; i++) begin
      apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h8, i[4:0], 5'd31 - i[4:0], 1'b0);
      check("reset_rs", rsData_D, 32'h0);
      check("reset_rt", rtData_D, 32'h0);
      next_cycle();
    end

    // ori $5 = 0x0000ABCD: bypass, then array.
    apply(32'h3405ABCD, 32'h0000ABCD, 32'hABCD0000, 32'h0, 32'h8, 5'd5, 5'd0, 1'b0);
    check("ori_en", {31'd0, wbEn_W}, 32'd1);
    check("ori_addr", {27'd0, wbAddr_W}, 32'd5);
    check("ori_bypass", rsData_D, 32'h0000ABCD);
    next_cycle();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd5, 5'd5, 1'b0);
    check("ori_array", rsData_D, 32'h0000ABCD);
    next_cycle();

    // lui $0 is discarded.
    apply(32'h3C001234, 32'h0, 32'h12340000, 32'h0, 32'h8, 5'd0, 5'd0, 1'b0);
    check("lui0_en", {31'd0, wbEn_W}, 32'd0);
    check("lui0_read", rsData_D, 32'h0);
    next_cycle();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 1'b0);
    check("lui0_after", rtData_D, 32'h0);
    next_cycle();

    // jal links to $31.
    apply(32'h0C000C00, 32'h0, 32'h0, 32'h0, 32'h00003008, 5'd1, 5'd2, 1'b0);
    check("jal_addr", {27'd0, wbAddr_W}, 32'd31);
    check("jal_data", wbData_W, 32'h00003008);
    next_cycle();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd31, 5'd5, 1'b0);
    check("jal_array", rsData_D, 32'h00003008);
    check("ori_kept", rtData_D, 32'h0000ABCD);
    next_cycle();

    // lw $7 read on both ports in the write cycle.
    apply(32'h8C070000, 32'h00000010, 32'h0, 32'hDEADBEEF, 32'h8, 5'd7, 5'd7, 1'b0);
    check("lw_rs", rsData_D, 32'hDEADBEEF);
    check("lw_rt", rtData_D, 32'hDEADBEEF);
    next_cycle();

    // Non-writing encodings: sw, beq, jr, and, plus sub $9 to show sub writes.
    apply(32'hAC040000, 32'h55555555, 32'h0, 32'h0, 32'h8, 5'd4, 5'd4, 1'b0);
    check("sw_en", {31'd0, wbEn_W}, 32'd0);
    check("sw_data", wbData_W, 32'h0);
    next_cycle();
    apply(32'h10220003, 32'h66666666, 32'h0, 32'h0, 32'h8, 5'd4, 5'd2, 1'b0);
    check("beq_addr", {27'd0, wbAddr_W}, 32'd0);
    next_cycle();
    apply(32'h03E00008, 32'h77777777, 32'h0, 32'h0, 32'h8, 5'd31, 5'd0, 1'b0);
    check("jr_en", {31'd0, wbEn_W}, 32'd0);
    check("jr_keep31", rsData_D, 32'h00003008);
    next_cycle();
    apply(32'h00224824, 32'h88888888, 32'h0, 32'h0, 32'h8, 5'd9, 5'd0, 1'b0);
    check("and_en", {31'd0, wbEn_W}, 32'd0);
    next_cycle();
    apply(32'h00224822, 32'h00000005, 32'h0, 32'h0, 32'h8, 5'd4, 5'd9, 1'b0);
    check("sub_bypass", rtData_D, 32'h00000005);
    check("sw_no_write", rsData_D, 32'h0);
    next_cycle();

    // Stalled W stage rewrites the same value.
    for (int i = 0; i < 3; i++) begin
      apply(32'h3405ABCD, 32'h0000ABCD, 32'h0, 32'h0, 32'h8, 5'd5, 5'd9, 1'b0);
      check("stall_rs", rsData_D, 32'h0000ABCD);
      check("stall_rt", rtData_D, 32'h00000005);
      next_cycle();
    end

    // $3 = 0x11111111, then reset concurrent with add $3 = 0x22222222.
    apply(32'h34030000, 32'h11111111, 32'h0, 32'h0, 32'h8, 5'd3, 5'd0, 1'b0);
    next_cycle();
    apply(32'h00221820, 32'h22222222, 32'h0, 32'h0, 32'h8, 5'd3, 5'd5, 1'b1);
    check("rst_bypass", rsData_D, 32'h22222222);
    check("rst_pre_rt", rtData_D, 32'h0000ABCD);
    next_cycle();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd3, 5'd31, 1'b0);
    check("rst_r3", rsData_D, 32'h0);
    check("rst_r31", rtData_D, 32'h0);
    next_cycle();

    // First write after reset commits normally.
    apply(32'h34030000, 32'h0BADF00D, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 1'b0);
    next_cycle();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd3, 5'd3, 1'b0);
    check("post_rst_write", rsData_D, 32'h0BADF00D);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
